// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control block.
package pipe_pkg;

  // Memory-wait sequencing states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2
  } state_t;

  // Per-stage enable/flush bundle for the pipeline registers.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_flush;
  } ctl_t;

  localparam int CNT_W_DEF = 32;

  // Controls held while reset is asserted: everything frozen and bubbled.
  localparam ctl_t CTL_RESET = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                 id_ex_flush: 1'b1, ex_mem_en: 1'b0, mem_wb_flush: 1'b1};
  // Free-running pipeline: all enables on, no flushes.
  localparam ctl_t CTL_RUN   = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                 id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_flush: 1'b0};

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear wins over increment; increment stops at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: turns hazard stalls, ID redirects and memory handshakes
// into per-stage enable/flush controls, with stall/flush counters and a
// stall watchdog.
import pipe_pkg::*;

module pipe_ctrl #(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_STALL = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             wdog_err
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] WDOG_LAST = RUN_W'(MAX_STALL - 1);

  state_t           state;
  state_t           state_nxt;
  logic             squash;
  logic             squash_nxt;
  ctl_t             ctl;
  logic             redirect;
  logic             data_wait;
  logic             stall_win;
  logic             run_inc;
  logic             run_clr;
  logic [RUN_W-1:0] run_cnt;

  assign redirect  = branch_taken | jump;
  // A new access that misses stalls from RUN or IWAIT; a pending one stalls
  // until dmem_ready.
  assign data_wait = ((state != DWAIT) && dmem_req && !dmem_ready) ||
                     ((state == DWAIT) && !dmem_ready);
  assign stall_win = stall_req && !data_wait;

  // Priority decode of the stage controls and next FSM state.
  always_comb begin
    ctl       = CTL_RUN;
    state_nxt = RUN;
    if (data_wait) begin
      ctl.pc_en        = 1'b0;
      ctl.if_id_en     = 1'b0;
      ctl.ex_mem_en    = 1'b0;
      ctl.mem_wb_flush = 1'b1;
      state_nxt        = DWAIT;
    end else if (stall_req) begin
      ctl.pc_en       = 1'b0;
      ctl.if_id_en    = 1'b0;
      ctl.id_ex_flush = 1'b1;
      state_nxt       = ((state == IWAIT) && !imem_ready) ? IWAIT : RUN;
    end else if (redirect) begin
      ctl.if_id_flush = 1'b1;
      state_nxt       = ((state == IWAIT) && !imem_ready) ? IWAIT : RUN;
    end else if (!imem_ready) begin
      ctl.pc_en       = 1'b0;
      ctl.if_id_flush = 1'b1;
      state_nxt       = IWAIT;
    end else if ((state == IWAIT) && squash) begin
      // Stale fetch returns after a redirect: drop it and hold the already
      // loaded target PC so the target is fetched next.
      ctl.pc_en       = 1'b0;
      ctl.if_id_flush = 1'b1;
      state_nxt       = RUN;
    end
    if (!rst) begin
      ctl = CTL_RESET;
    end
  end

  // Remember a redirect taken while a fetch is still outstanding.
  always_comb begin
    squash_nxt = 1'b0;
    if (state_nxt == IWAIT) begin
      squash_nxt = squash ||
                   ((state == IWAIT) && redirect && !stall_req && !data_wait);
    end
  end

  // FSM state and squash flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      squash <= 1'b0;
    end else begin
      state  <= state_nxt;
      squash <= squash_nxt;
    end
  end

  assign pc_en        = ctl.pc_en;
  assign if_id_en     = ctl.if_id_en;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_flush  = ctl.id_ex_flush;
  assign ex_mem_en    = ctl.ex_mem_en;
  assign mem_wb_flush = ctl.mem_wb_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!ctl.pc_en),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctl.if_id_flush),
    .clr   (1'b0),
    .count (flush_cnt)
  );

  // Run length of consecutive hazard stalls; frozen during data waits.
  assign run_inc = stall_win;
  assign run_clr = !stall_req && !data_wait;

  sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (run_inc),
    .clr   (run_clr),
    .count (run_cnt)
  );

  // Sticky watchdog flag, set on the stall cycle that reaches MAX_STALL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_err <= 1'b0;
    end else if (run_inc && (run_cnt == WDOG_LAST)) begin
      wdog_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle model pushes expected controls and
// counter values when inputs are driven; they are popped and compared when the
// DUT responds.
module tb_pipe_ctrl;

  localparam int CNT_W     = 4;
  localparam int MAX_STALL = 16;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall_req, branch_taken, jump, imem_ready, dmem_req, dmem_ready;
  logic             pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             wdog_err;
  logic [5:0]       ctl_vec;

  typedef struct {
    logic [5:0]       ctl;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    logic             wd;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state.
  int m_st, m_run, m_sc, m_fc;
  bit m_sq, m_wd;

  pipe_ctrl #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .branch_taken (branch_taken),
    .jump         (jump),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_flush (mem_wb_flush),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .wdog_err     (wdog_err)
  );

  assign ctl_vec = {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_flush};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_in(input bit sr, input bit br, input bit jp,
                        input bit ir, input bit dq, input bit dr);
    stall_req    = sr;
    branch_taken = br;
    jump         = jp;
    imem_ready   = ir;
    dmem_req     = dq;
    dmem_ready   = dr;
  endtask

  // One pipeline cycle: drive, predict, compare controls mid-cycle and
  // counters just after the edge. Called and returns at posedge+1.
  task automatic step(input bit sr, input bit br, input bit jp,
                      input bit ir, input bit dq, input bit dr);
    exp_t       e;
    exp_t       got_e;
    bit         dw;
    int         ns;
    logic [5:0] c;
    set_in(sr, br, jp, ir, dq, dr);
    dw = (m_st != 1 && dq && !dr) || (m_st == 1 && !dr);
    if (dw)                        begin c = 6'b000001; ns = 1; end
    else if (sr)                   begin c = 6'b000110; ns = (m_st == 2 && !ir) ? 2 : 0; end
    else if (br || jp)             begin c = 6'b111010; ns = (m_st == 2 && !ir) ? 2 : 0; end
    else if (!ir)                  begin c = 6'b011010; ns = 2; end
    else if (m_st == 2 && m_sq)    begin c = 6'b011010; ns = 0; end
    else                           begin c = 6'b110010; ns = 0; end
    if (!c[5] && m_sc < CMAX) m_sc++;
    if (c[3]  && m_fc < CMAX) m_fc++;
    if (!dw) begin
      if (sr) begin
        if (m_run == MAX_STALL - 1) m_wd = 1'b1;
        m_run++;
      end else begin
        m_run = 0;
      end
    end
    m_sq = (ns == 2) && (m_sq || (m_st == 2 && !dw && !sr && (br || jp)));
    m_st = ns;
    e.ctl = c;
    e.sc  = CNT_W'(m_sc);
    e.fc  = CNT_W'(m_fc);
    e.wd  = m_wd;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      @(posedge clk);
      #1;
    end else begin
      got_e = sb.pop_front();
      chk("ctl", {26'd0, ctl_vec}, {26'd0, got_e.ctl});
      @(posedge clk);
      #1;
      chk("stall_cnt", {28'd0, stall_cnt}, {28'd0, got_e.sc});
      chk("flush_cnt", {28'd0, flush_cnt}, {28'd0, got_e.fc});
      chk("wdog_err", {31'd0, wdog_err}, {31'd0, got_e.wd});
    end
  endtask

  // Assert reset, check reset values, release on a falling edge.
  task automatic do_reset();
    set_in(0, 0, 0, 1, 0, 0);
    rst = 1'b0;
    #1;
    chk("rst_ctl", {26'd0, ctl_vec}, {26'd0, 6'b001101});
    chk("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("rst_flush_cnt", {28'd0, flush_cnt}, 32'd0);
    chk("rst_wdog", {31'd0, wdog_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_st = 0; m_sq = 0; m_run = 0; m_sc = 0; m_fc = 0; m_wd = 0;
  endtask

  initial begin
    int f0;
    rst = 1'b0;
    set_in(0, 0, 0, 1, 0, 0);
    do_reset();

    // Idle run after reset, then a single-cycle hazard stall.
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("one_stall_cnt", {28'd0, stall_cnt}, 32'd1);
    step(0, 0, 0, 1, 0, 0);
    chk("one_stall_after", {26'd0, ctl_vec}, {26'd0, 6'b110010});

    // Data wait with stall and jump pending; completion applies the stall only.
    do_reset();
    repeat (3) step(1, 0, 1, 1, 1, 0);
    step(1, 0, 1, 1, 1, 1);
    chk("dwait_stall_cnt", {28'd0, stall_cnt}, 32'd4);
    chk("dwait_flush_cnt", {28'd0, flush_cnt}, 32'd0);
    step(0, 0, 0, 1, 0, 0);

    // Jump while a fetch is outstanding; the late fetch is squashed.
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    f0 = int'(flush_cnt);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("iwait_flush_delta", int'(flush_cnt) - f0, 32'd2);
    step(0, 0, 0, 1, 0, 0);

    // Watchdog: 16 consecutive stalls, sticky afterwards; counter saturation.
    do_reset();
    repeat (15) step(1, 0, 0, 1, 0, 0);
    chk("wdog_before", {31'd0, wdog_err}, 32'd0);
    step(1, 0, 0, 1, 0, 0);
    chk("wdog_fire", {31'd0, wdog_err}, 32'd1);
    chk("stall_sat", {28'd0, stall_cnt}, CMAX);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    chk("wdog_sticky", {31'd0, wdog_err}, 32'd1);

    // Reset asserted while waiting on data memory.
    do_reset();
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    rst = 1'b0;
    #1;
    chk("midrst_ctl", {26'd0, ctl_vec}, {26'd0, 6'b001101});
    chk("midrst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    do_reset();
    step(0, 0, 0, 1, 0, 0);
    chk("midrst_run", {26'd0, ctl_vec}, {26'd0, 6'b110010});

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
